ibex_obi_bridge: RTL and testbench
==================================

Name: ibex_obi_bridge

Overview:
- Parametrised bridge between an Ibex-style OBI port (req/gnt/rvalid, one per instruction or data side) and a valid/ready request/response fabric channel.
- Adds configurable outstanding-transaction depth, an optional registered request stage and a response watchdog that returns a synthetic error response when the fabric stalls.
- One instance sits on each core memory port inside the next-generation core wrapper.

Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; multiple of 8
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions; range 1..15
- REQ_REG, 1, 1 = registered A-channel stage; 0 = combinational pass-through
- TIMEOUT_CYCLES, 1024, watchdog limit; 0 disables the watchdog

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req_i  in  1  core request
- gnt_o  out  1  request accepted this cycle
- we_i  in  1  write enable
- be_i  in  DATA_WIDTH/8  byte enables
- addr_i  in  ADDR_WIDTH  address
- wdata_i  in  DATA_WIDTH  write data
- rvalid_o  out  1  response valid, one-cycle pulse per transaction
- rdata_o  out  DATA_WIDTH  read data
- err_o  out  1  response error, qualified by rvalid_o
- a_valid_o  out  1  fabric request valid
- a_ready_i  in  1  fabric request ready
- a_we_o, a_be_o, a_addr_o, a_wdata_o  out  as core side  fabric request payload
- d_valid_i  in  1  fabric response valid
- d_ready_o  out  1  fabric response ready; constant 1
- d_rdata_i  in  DATA_WIDTH  fabric read data
- d_err_i  in  1  fabric error
- outstanding_o  out  4  current outstanding count
- timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset: gnt_o, rvalid_o, err_o, a_valid_o, timeout_o = 0. rdata_o, a_* payload = 0. Counters = 0.
- credit = (outstanding + drop_cnt) < MAX_OUTSTANDING.
- REQ_REG=0:
  - gnt_o = req_i & credit & a_ready_i.
  - a_valid_o = req_i & credit.
  - Payload passes through combinationally.
- REQ_REG=1:
  - gnt_o = req_i & credit & (!a_valid_o | a_ready_i).
  - On gnt_o, the payload is captured and a_valid_o is set the next cycle.
  - a_valid_o clears on a_ready_i unless a new grant occurs in the same cycle.
  - Payload is stable while a_valid_o & !a_ready_i.
  - Back-to-back throughput is 1 request per cycle.
- outstanding:
  - +1 on gnt_o.
  - −1 on each response delivered to the core (real or synthetic).
  - Grant and response in the same cycle leave it unchanged.
- Response path, registered with 1-cycle latency:
  - On d_valid_i with drop_cnt==0: rvalid_o=1, rdata_o=d_rdata_i, err_o=d_err_i next cycle.
  - On d_valid_i with drop_cnt>0: the response is discarded, drop_cnt −1, no rvalid_o.
  - rdata_o holds its last value when rvalid_o=0.
- Watchdog (TIMEOUT_CYCLES>0):
  - wd_cnt clears when outstanding==0 or when any d_valid_i occurs.
  - Otherwise wd_cnt increments each cycle.
  - When wd_cnt == TIMEOUT_CYCLES−1 and no d_valid_i in that cycle:
    - Next cycle: rvalid_o=1, err_o=1, rdata_o=0, timeout_o=1.
    - outstanding −1, drop_cnt +1, wd_cnt cleared.
    - Each remaining outstanding transaction times out after a further TIMEOUT_CYCLES.
- d_valid_i and watchdog expiry in the same cycle: the real response wins and no timeout fires.
- Responses are in order; the fabric guarantees ordering. A synthetic error always retires the oldest transaction.
- d_valid_i with outstanding==0 and drop_cnt==0 is a protocol violation. Ignore it and raise an assertion.
- Reset asserted mid-transaction clears all state, including the A-stage register and drop_cnt. No response is issued for lost transactions.
- Counter widths: 4 bits each. MAX_OUTSTANDING ≤ 15 is checked by an elaboration assertion.

Decomposition:
- Package ibex_obi_bridge_pkg holds:
  - obi_req_t struct (we, be, addr, wdata), parametrised via macros/widths.
  - obi_rsp_t struct (rdata, err).
  - Constant CNT_W = 4.
- Sub-module ibex_obi_req_stage: the one-entry A-channel register/pass-through selected by REQ_REG. It holds the valid/ready logic and payload hold.

Test Plan:
- Single read, REQ_REG=1, a_ready_i=1, d_valid_i 3 cycles after a_valid_o with rdata=0xDEADBEEF → gnt_o 1 cycle; rvalid_o 1 cycle after d_valid_i; rdata_o=0xDEADBEEF; err_o=0; outstanding_o back to 0.
- MAX_OUTSTANDING=2, req_i held high, responses withheld → exactly 2 grants; gnt_o stays 0 and outstanding_o=2 until the first d_valid_i; third grant in the same cycle as that response.
- a_ready_i=0 for 5 cycles with REQ_REG=1 → a_valid_o held; payload unchanged (addr 0x8000_0010, be 0xF); one fabric handshake only.
- TIMEOUT_CYCLES=16, one read, no response → after 16 cycles rvalid_o=1, err_o=1, rdata_o=0, timeout_o=1; a late d_valid_i is dropped with no rvalid_o; credit is restored after the drop.
- d_valid_i in exactly the watchdog expiry cycle → real response delivered; timeout_o stays 0.
- rst_i pulsed with 2 transactions outstanding and a_valid_o=1 → all outputs 0 next edge; subsequent d_valid_i ignored with an assertion flagged; normal operation resumes.

Source files
------------

// File: rtl/ibex_obi_bridge_pkg.sv
// ibex_obi_bridge_pkg: request/response payload types and counter width shared by the OBI bridge
`ifndef IBEX_OBI_REQ_T
`define IBEX_OBI_REQ_T(AW, DW) struct packed { logic we; logic [(DW)/8-1:0] be; logic [(AW)-1:0] addr; logic [(DW)-1:0] wdata; }
`define IBEX_OBI_RSP_T(DW) struct packed { logic [(DW)-1:0] rdata; logic err; }
`endif

package ibex_obi_bridge_pkg;

    localparam int CNT_W = 4;

    typedef `IBEX_OBI_REQ_T(32, 32) obi_req_t;
    typedef `IBEX_OBI_RSP_T(32) obi_rsp_t;

    function automatic logic [CNT_W-1:0] cnt_step(
        input logic [CNT_W-1:0] c,
        input logic             inc,
        input logic             dec
    );
        return c + CNT_W'(inc) - CNT_W'(dec);
    endfunction

endpackage

// File: rtl/ibex_obi_req_stage.sv
// ibex_obi_req_stage: one-entry A-channel register, or a combinational pass-through when REQ_REG=0
module ibex_obi_req_stage
    import ibex_obi_bridge_pkg::*;
#(
    parameter int  REQ_REG = 1,
    parameter type T       = logic
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req,
    input  logic i_credit,
    input  T     i_data,
    output logic o_gnt,
    output logic o_a_valid,
    input  logic i_a_ready,
    output T     o_a_data
);

    logic r_valid;
    T     r_data;

    // The register only refills when it is empty or draining this cycle, giving one request per cycle.
    always_comb begin
        o_gnt     = i_req & i_credit & ((REQ_REG != 0) ? (!r_valid | i_a_ready) : i_a_ready);
        o_a_valid = (REQ_REG != 0) ? r_valid : (i_req & i_credit);
        o_a_data  = (REQ_REG != 0) ? r_data : i_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= o_gnt | (r_valid & !i_a_ready);
            if (o_gnt) r_data <= i_data;
        end
    end

endmodule

// File: rtl/ibex_obi_bridge.sv
// ibex_obi_bridge: OBI req/gnt/rvalid port to valid/ready fabric channel with credit limit and response watchdog
module ibex_obi_bridge
    import ibex_obi_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int REQ_REG         = 1,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o,
    output logic                    a_valid_o,
    input  logic                    a_ready_i,
    output logic                    a_we_o,
    output logic [DATA_WIDTH/8-1:0] a_be_o,
    output logic [ADDR_WIDTH-1:0]   a_addr_o,
    output logic [DATA_WIDTH-1:0]   a_wdata_o,
    input  logic                    d_valid_i,
    output logic                    d_ready_o,
    input  logic [DATA_WIDTH-1:0]   d_rdata_i,
    input  logic                    d_err_i,
    output logic [3:0]              outstanding_o,
    output logic                    timeout_o
);

    typedef `IBEX_OBI_REQ_T(ADDR_WIDTH, DATA_WIDTH) req_t;
    typedef `IBEX_OBI_RSP_T(DATA_WIDTH) rsp_t;

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int SUM_W = CNT_W + 1;

    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15) begin : g_bad_max
        $error("ibex_obi_bridge: MAX_OUTSTANDING must lie in 1..15");
    end
    if (DATA_WIDTH % 8 != 0) begin : g_bad_dw
        $error("ibex_obi_bridge: DATA_WIDTH must be a multiple of 8");
    end

    logic [CNT_W-1:0] r_out;
    logic [CNT_W-1:0] r_drop;
    logic [WD_W-1:0]  r_wd;
    logic             r_rvalid;
    logic             r_timeout;
    rsp_t             r_rsp;
    logic             w_credit;
    logic             w_gnt;
    logic             w_deliver;
    logic             w_drop;
    logic             w_expire;
    req_t             w_core_req;
    req_t             w_a_req;

    // Timed-out transactions keep their credit until the fabric's late answer has been swallowed.
    always_comb begin
        w_credit   = ({1'b0, r_out} + {1'b0, r_drop}) < SUM_W'(MAX_OUTSTANDING);
        w_deliver  = d_valid_i && r_drop == '0 && r_out != '0;
        w_drop     = d_valid_i && r_drop != '0;
        w_expire   = TIMEOUT_CYCLES > 0 && r_out != '0 && !d_valid_i && r_wd == WD_W'(TIMEOUT_CYCLES - 1);
        w_core_req = '{we: we_i, be: be_i, addr: addr_i, wdata: wdata_i};
    end

    ibex_obi_req_stage #(
        .REQ_REG (REQ_REG),
        .T       (req_t)
    ) u_req_stage (
        .i_clk     (clk_i),
        .i_rst     (rst_i),
        .i_req     (req_i),
        .i_credit  (w_credit),
        .i_data    (w_core_req),
        .o_gnt     (w_gnt),
        .o_a_valid (a_valid_o),
        .i_a_ready (a_ready_i),
        .o_a_data  (w_a_req)
    );

    always_comb begin
        gnt_o         = w_gnt;
        a_we_o        = w_a_req.we;
        a_be_o        = w_a_req.be;
        a_addr_o      = w_a_req.addr;
        a_wdata_o     = w_a_req.wdata;
        d_ready_o     = 1'b1;
        rvalid_o      = r_rvalid;
        rdata_o       = r_rsp.rdata;
        err_o         = r_rsp.err;
        outstanding_o = r_out;
        timeout_o     = r_timeout;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_out     <= '0;
            r_drop    <= '0;
            r_wd      <= '0;
            r_rvalid  <= 1'b0;
            r_timeout <= 1'b0;
            r_rsp     <= '0;
        end else begin
            r_out     <= cnt_step(r_out, w_gnt, w_deliver | w_expire);
            r_drop    <= cnt_step(r_drop, w_expire, w_drop);
            r_wd      <= (TIMEOUT_CYCLES == 0 || r_out == '0 || d_valid_i || w_expire) ? '0 : r_wd + 1'b1;
            r_rvalid  <= w_deliver | w_expire;
            r_timeout <= w_expire;
            if (w_deliver | w_expire)
                r_rsp <= w_deliver ? rsp_t'{rdata: d_rdata_i, err: d_err_i} : rsp_t'{rdata: '0, err: 1'b1};
        end
    end

    // A response with nothing outstanding or pending drop is a fabric protocol violation; it is ignored.
    always_ff @(posedge clk_i) begin
        if (!rst_i)
            assert (!(d_valid_i && r_out == '0 && r_drop == '0))
            else $warning("ibex_obi_bridge: d_valid_i with no transaction outstanding, ignored");
    end

endmodule

// File: tb/tb_ibex_obi_bridge.sv
// tb_ibex_obi_bridge: directed scenarios plus randomized traffic against a transaction-level model
module tb_ibex_obi_bridge;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXO = 2;
    localparam int TO   = 16;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          req_i = 1'b0;
    logic          we_i = 1'b0;
    logic [BW-1:0] be_i = '0;
    logic [AW-1:0] addr_i = '0;
    logic [DW-1:0] wdata_i = '0;
    logic          a_ready_i = 1'b1;
    logic          d_valid_i = 1'b0;
    logic [DW-1:0] d_rdata_i = '0;
    logic          d_err_i = 1'b0;
    logic          gnt_o, rvalid_o, err_o, a_valid_o, a_we_o, d_ready_o, timeout_o;
    logic [DW-1:0] rdata_o, a_wdata_o;
    logic [BW-1:0] a_be_o;
    logic [AW-1:0] a_addr_o;
    logic [3:0]    outstanding_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    ibex_obi_bridge #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MAXO),
        .REQ_REG         (1),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .gnt_o         (gnt_o),
        .we_i          (we_i),
        .be_i          (be_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .rvalid_o      (rvalid_o),
        .rdata_o       (rdata_o),
        .err_o         (err_o),
        .a_valid_o     (a_valid_o),
        .a_ready_i     (a_ready_i),
        .a_we_o        (a_we_o),
        .a_be_o        (a_be_o),
        .a_addr_o      (a_addr_o),
        .a_wdata_o     (a_wdata_o),
        .d_valid_i     (d_valid_i),
        .d_ready_o     (d_ready_o),
        .d_rdata_i     (d_rdata_i),
        .d_err_i       (d_err_i),
        .outstanding_o (outstanding_o),
        .timeout_o     (timeout_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        req_i = 1'b0;
        a_ready_i = 1'b1;
        d_valid_i = 1'b0;
        d_err_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        idle();
        repeat (2) tick();
        #1;
        checks++; if ({gnt_o, rvalid_o, err_o, a_valid_o, timeout_o} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 00000", {gnt_o, rvalid_o, err_o, a_valid_o, timeout_o}); end
        checks++; if ({rdata_o, a_we_o, a_be_o, a_addr_o, a_wdata_o} !== '0) begin errors++; $display("FAIL reset_payload: got rdata=%h addr=%h wdata=%h be=%h want all 0", rdata_o, a_addr_o, a_wdata_o, a_be_o); end
        checks++; if (outstanding_o !== 4'd0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", outstanding_o); end
        checks++; if (d_ready_o !== 1'b1) begin errors++; $display("FAIL reset_d_ready: got %b want 1", d_ready_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_single_read();
        int gnts = 0;
        tick(); req_i = 1; we_i = 0; be_i = 4'hF; addr_i = 32'h1000_0004; wdata_i = '0; #1;
        gnts += int'(gnt_o);
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL sr_gnt: got %b want 1", gnt_o); end
        tick(); req_i = 0; #1;
        gnts += int'(gnt_o);
        checks++; if (a_valid_o !== 1'b1 || a_addr_o !== 32'h1000_0004 || a_we_o !== 1'b0) begin errors++; $display("FAIL sr_a_chan: got valid=%b addr=%h we=%b want 1 10000004 0", a_valid_o, a_addr_o, a_we_o); end
        checks++; if (outstanding_o !== 4'd1) begin errors++; $display("FAIL sr_out1: got %0d want 1", outstanding_o); end
        tick(); #1;
        checks++; if (a_valid_o !== 1'b0 || rvalid_o !== 1'b0) begin errors++; $display("FAIL sr_idle: got a_valid=%b rvalid=%b want 0 0", a_valid_o, rvalid_o); end
        tick();
        tick(); d_valid_i = 1; d_rdata_i = 32'hDEAD_BEEF; d_err_i = 0; #1;
        checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL sr_early_rvalid: got %b want 0", rvalid_o); end
        tick(); d_valid_i = 0; #1;
        checks++; if (rvalid_o !== 1'b1 || rdata_o !== 32'hDEAD_BEEF || err_o !== 1'b0) begin errors++; $display("FAIL sr_rsp: got rvalid=%b rdata=%h err=%b want 1 deadbeef 0", rvalid_o, rdata_o, err_o); end
        checks++; if (outstanding_o !== 4'd0) begin errors++; $display("FAIL sr_out0: got %0d want 0", outstanding_o); end
        tick(); #1;
        checks++; if (rvalid_o !== 1'b0 || rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sr_hold: got rvalid=%b rdata=%h want 0 deadbeef", rvalid_o, rdata_o); end
        checks++; if (gnts != 1) begin errors++; $display("FAIL sr_gnt_count: got %0d want 1", gnts); end
    endtask

    task automatic test_max_outstanding();
        int gnts = 0;
        for (int c = 0; c < 7; c++) begin
            tick();
            req_i = 1; we_i = 0; addr_i = 32'h2000_0000 + 32'(c * 4);
            d_valid_i = (c == 6); d_rdata_i = 32'h1;
            #1;
            gnts += int'(gnt_o);
            if (c >= 2) begin
                checks++; if (gnt_o !== 1'b0 || outstanding_o !== 4'(MAXO)) begin errors++; $display("FAIL mo_stall c%0d: got gnt=%b out=%0d want 0 %0d", c, gnt_o, outstanding_o, MAXO); end
            end
        end
        checks++; if (gnts != MAXO) begin errors++; $display("FAIL mo_gnt_count: got %0d want %0d", gnts, MAXO); end
        tick(); d_valid_i = 0; #1;
        checks++; if (gnt_o !== 1'b1 || rvalid_o !== 1'b1 || rdata_o !== 32'h1) begin errors++; $display("FAIL mo_third_gnt: got gnt=%b rvalid=%b rdata=%h want 1 1 1", gnt_o, rvalid_o, rdata_o); end
        tick(); req_i = 0; d_valid_i = 1; d_rdata_i = 32'h2; #1;
        checks++; if (outstanding_o !== 4'd2) begin errors++; $display("FAIL mo_out_after: got %0d want 2", outstanding_o); end
        tick(); d_valid_i = 1; d_rdata_i = 32'h3; #1;
        tick(); d_valid_i = 0; #1;
        checks++; if (outstanding_o !== 4'd0 || rvalid_o !== 1'b1 || rdata_o !== 32'h3) begin errors++; $display("FAIL mo_drain: got out=%0d rvalid=%b rdata=%h want 0 1 3", outstanding_o, rvalid_o, rdata_o); end
    endtask

    task automatic test_backpressure();
        int hs = 0;
        tick(); req_i = 1; we_i = 1; be_i = 4'hF; addr_i = 32'h8000_0010; wdata_i = 32'h1234_5678; a_ready_i = 0; #1;
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL bp_gnt: got %b want 1", gnt_o); end
        for (int c = 1; c <= 5; c++) begin
            tick(); req_i = 1; we_i = 0; be_i = 4'h1; addr_i = 32'h0000_0020; wdata_i = '0; #1;
            hs += int'(a_valid_o & a_ready_i);
            checks++; if (a_valid_o !== 1'b1 || {a_we_o, a_be_o, a_addr_o, a_wdata_o} !== {1'b1, 4'hF, 32'h8000_0010, 32'h1234_5678} || gnt_o !== 1'b0) begin errors++; $display("FAIL bp_hold c%0d: got valid=%b we=%b be=%h addr=%h wdata=%h gnt=%b want 1 1 f 80000010 12345678 0", c, a_valid_o, a_we_o, a_be_o, a_addr_o, a_wdata_o, gnt_o); end
        end
        tick(); req_i = 0; a_ready_i = 1; #1;
        hs += int'(a_valid_o & a_ready_i);
        checks++; if (a_addr_o !== 32'h8000_0010) begin errors++; $display("FAIL bp_release_addr: got %h want 80000010", a_addr_o); end
        tick(); d_valid_i = 1; d_rdata_i = '0; d_err_i = 0; #1;
        hs += int'(a_valid_o & a_ready_i);
        checks++; if (a_valid_o !== 1'b0) begin errors++; $display("FAIL bp_clear: got a_valid=%b want 0", a_valid_o); end
        tick(); d_valid_i = 0; #1;
        checks++; if (rvalid_o !== 1'b1 || err_o !== 1'b0 || outstanding_o !== 4'd0) begin errors++; $display("FAIL bp_rsp: got rvalid=%b err=%b out=%0d want 1 0 0", rvalid_o, err_o, outstanding_o); end
        checks++; if (hs != 1) begin errors++; $display("FAIL bp_handshakes: got %0d want 1", hs); end
    endtask

    task automatic test_timeout();
        int first_rv = -1;
        tick(); req_i = 1; we_i = 0; addr_i = 32'h40; a_ready_i = 1; #1;
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL to_gnt: got %b want 1", gnt_o); end
        for (int c = 1; c <= TO + 1; c++) begin
            tick(); req_i = 0; #1;
            if (rvalid_o === 1'b1 && first_rv < 0) first_rv = c;
        end
        checks++; if (first_rv != TO + 1) begin errors++; $display("FAIL to_latency: got cycle %0d want %0d", first_rv, TO + 1); end
        checks++; if ({rvalid_o, err_o, timeout_o} !== 3'b111 || rdata_o !== '0 || outstanding_o !== 4'd0) begin errors++; $display("FAIL to_rsp: got rvalid=%b err=%b timeout=%b rdata=%h out=%0d want 1 1 1 0 0", rvalid_o, err_o, timeout_o, rdata_o, outstanding_o); end
        tick(); #1;
        checks++; if (timeout_o !== 1'b0 || rvalid_o !== 1'b0) begin errors++; $display("FAIL to_pulse: got timeout=%b rvalid=%b want 0 0", timeout_o, rvalid_o); end
        tick(); d_valid_i = 1; d_rdata_i = 32'hBAD; #1;
        tick(); d_valid_i = 0; req_i = 1; addr_i = 32'h44; #1;
        checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL to_late_dropped: got rvalid=%b want 0", rvalid_o); end
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL to_credit1: got %b want 1", gnt_o); end
        tick(); req_i = 1; addr_i = 32'h48; #1;
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL to_credit2: got %b want 1", gnt_o); end
        tick(); req_i = 0; d_valid_i = 1; d_rdata_i = 32'h44; #1;
        checks++; if (outstanding_o !== 4'd2) begin errors++; $display("FAIL to_out2: got %0d want 2", outstanding_o); end
        tick(); d_valid_i = 1; d_rdata_i = 32'h48; #1;
        tick(); d_valid_i = 0; #1;
        checks++; if (outstanding_o !== 4'd0 || rdata_o !== 32'h48 || err_o !== 1'b0) begin errors++; $display("FAIL to_recover: got out=%0d rdata=%h err=%b want 0 48 0", outstanding_o, rdata_o, err_o); end
    endtask

    task automatic test_timeout_race();
        int early = 0;
        tick(); req_i = 1; addr_i = 32'h80; #1;
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL race_gnt: got %b want 1", gnt_o); end
        for (int c = 1; c <= TO; c++) begin
            tick(); req_i = 0; d_valid_i = (c == TO); d_rdata_i = 32'hCAFE_F00D; d_err_i = 0; #1;
            early += int'(rvalid_o);
        end
        checks++; if (early != 0) begin errors++; $display("FAIL race_early: got %0d rvalid cycles want 0", early); end
        tick(); d_valid_i = 0; #1;
        checks++; if ({rvalid_o, err_o, timeout_o} !== 3'b100 || rdata_o !== 32'hCAFE_F00D || outstanding_o !== 4'd0) begin errors++; $display("FAIL race_rsp: got rvalid=%b err=%b timeout=%b rdata=%h out=%0d want 1 0 0 cafef00d 0", rvalid_o, err_o, timeout_o, rdata_o, outstanding_o); end
        tick(); #1;
        checks++; if (timeout_o !== 1'b0 || rvalid_o !== 1'b0) begin errors++; $display("FAIL race_after: got timeout=%b rvalid=%b want 0 0", timeout_o, rvalid_o); end
    endtask

    task automatic test_reset_mid();
        tick(); req_i = 1; addr_i = 32'h100; a_ready_i = 1; #1;
        tick(); req_i = 1; addr_i = 32'h104; #1;
        tick(); req_i = 0; a_ready_i = 0; #1;
        checks++; if (outstanding_o !== 4'd2 || a_valid_o !== 1'b1 || a_addr_o !== 32'h104) begin errors++; $display("FAIL rm_pre: got out=%0d a_valid=%b addr=%h want 2 1 104", outstanding_o, a_valid_o, a_addr_o); end
        rst_i = 1; #1;
        checks++; if (a_valid_o !== 1'b0 || outstanding_o !== 4'd0) begin errors++; $display("FAIL rm_async: got a_valid=%b out=%0d want 0 0", a_valid_o, outstanding_o); end
        tick(); #1;
        checks++; if ({gnt_o, rvalid_o, err_o, a_valid_o, timeout_o} !== 5'b0 || outstanding_o !== 4'd0 || {rdata_o, a_addr_o, a_be_o, a_wdata_o, a_we_o} !== '0) begin errors++; $display("FAIL rm_all_zero: got ctrl=%b out=%0d rdata=%h addr=%h want 0", {gnt_o, rvalid_o, err_o, a_valid_o, timeout_o}, outstanding_o, rdata_o, a_addr_o); end
        rst_i = 0; a_ready_i = 1;
        tick(); d_valid_i = 1; d_rdata_i = 32'h55; #1;
        tick(); d_valid_i = 0; #1;
        checks++; if (rvalid_o !== 1'b0 || outstanding_o !== 4'd0 || rdata_o !== '0) begin errors++; $display("FAIL rm_stray: got rvalid=%b out=%0d rdata=%h want 0 0 0", rvalid_o, outstanding_o, rdata_o); end
        tick(); req_i = 1; addr_i = 32'h200; #1;
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL rm_resume_gnt: got %b want 1", gnt_o); end
        tick(); req_i = 0; #1;
        tick(); d_valid_i = 1; d_rdata_i = 32'h77; #1;
        tick(); d_valid_i = 0; #1;
        checks++; if (rvalid_o !== 1'b1 || rdata_o !== 32'h77 || outstanding_o !== 4'd0) begin errors++; $display("FAIL rm_resume_rsp: got rvalid=%b rdata=%h out=%0d want 1 77 0", rvalid_o, rdata_o, outstanding_o); end
    endtask

    // Model: credits, an A-stage slot, a fabric FIFO count and a per-oldest-transaction silence timer.
    task automatic test_random();
        int m_out = 0, m_drop = 0, m_quiet = 0, fab = 0;
        bit m_aval = 0, m_rv = 0, m_err = 0, m_to = 0;
        bit stall, credit, eg, deliver, dropped, expire;
        logic [DW-1:0] m_rd = '0;
        logic [AW+DW+BW:0] m_apay = '0;
        idle();
        repeat (2) tick();
        for (int i = 0; i < 600; i++) begin
            tick();
            stall = ((i / 50) % 3) == 2;
            req_i = ($urandom_range(0, 2) != 0);
            we_i = 1'($urandom_range(0, 1));
            be_i = 4'($urandom);
            addr_i = $urandom;
            wdata_i = $urandom;
            a_ready_i = ($urandom_range(0, 3) != 0);
            d_valid_i = (fab > 0) && !stall && ($urandom_range(0, 1) == 1);
            d_rdata_i = $urandom;
            d_err_i = ($urandom_range(0, 7) == 0);
            #1;
            credit = (m_out + m_drop) < MAXO;
            eg = req_i && credit && (!m_aval || a_ready_i);
            checks++; if ({gnt_o, a_valid_o, rvalid_o, timeout_o} !== {eg, m_aval, m_rv, m_to} || outstanding_o !== 4'(m_out)) begin errors++; $display("FAIL rnd_ctrl i=%0d: got gnt/av/rv/to=%b out=%0d want %b out=%0d", i, {gnt_o, a_valid_o, rvalid_o, timeout_o}, outstanding_o, {eg, m_aval, m_rv, m_to}, m_out); end
            if (m_aval) begin
                checks++; if ({a_we_o, a_be_o, a_addr_o, a_wdata_o} !== m_apay) begin errors++; $display("FAIL rnd_payload i=%0d: got %h want %h", i, {a_we_o, a_be_o, a_addr_o, a_wdata_o}, m_apay); end
            end
            if (m_rv) begin
                checks++; if ({rdata_o, err_o} !== {m_rd, m_err}) begin errors++; $display("FAIL rnd_rsp i=%0d: got rdata=%h err=%b want %h %b", i, rdata_o, err_o, m_rd, m_err); end
            end
            deliver = d_valid_i && m_drop == 0;
            dropped = d_valid_i && m_drop > 0;
            expire = m_out > 0 && m_quiet == TO - 1 && !d_valid_i;
            if (d_valid_i) fab--;
            if (m_aval && a_ready_i) fab++;
            m_quiet = (m_out == 0 || d_valid_i || expire) ? 0 : m_quiet + 1;
            m_rv = deliver || expire;
            m_to = expire;
            if (deliver) begin m_rd = d_rdata_i; m_err = d_err_i; end
            else if (expire) begin m_rd = '0; m_err = 1'b1; end
            m_out = m_out + int'(eg) - int'(deliver || expire);
            m_drop = m_drop + int'(expire) - int'(dropped);
            if (eg) begin m_aval = 1; m_apay = {we_i, be_i, addr_i, wdata_i}; end
            else if (a_ready_i) m_aval = 0;
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "tb_ibex_obi_bridge: time limit");
    end

    initial begin
        test_reset();
        test_single_read();
        test_max_outstanding();
        idle();
        test_backpressure();
        idle();
        test_timeout();
        idle();
        test_timeout_race();
        idle();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
